// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: walks NST qualifying stages, optional post-trigger delay, one-cycle capture-start pulse.
// Optional stage timeout is enabled with `define TRIGGER_SEQUENCER_TIMEOUT_EN.
module trigger_sequencer #(
    parameter int NEV = 4,
    parameter int NST = 4,
    parameter int CNW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctl_arm,
    input  logic                   ctl_abort,
    input  logic [NST*NEV-1:0]     cfg_sel,
    input  logic [NST*CNW-1:0]     cfg_cnt,
    input  logic [NST-1:0]         cfg_lst,
    input  logic [CNW-1:0]         cfg_dly,
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    input  logic [CNW-1:0]         cfg_tmo,
`endif
    input  logic                   sti_transfer,
    input  logic [NEV-1:0]         evt_in,
    output logic                   sts_arm,
    output logic [$clog2(NST)-1:0] sts_stg,
    output logic                   sts_trg,
    output logic                   sts_dne
);
    localparam int SW = $clog2(NST);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, DONE} state_t;

    state_t         state;
    logic [CNW-1:0] occ;
    logic [CNW-1:0] dcnt;
    logic [NEV-1:0] sel;
    logic [CNW-1:0] cnt;
    logic           qual;
    logic           met;
    logic           last;
    logic           dly_hit;
    logic           tmo_fire;

    assign sel  = cfg_sel[int'(sts_stg)*NEV +: NEV];
    assign cnt  = cfg_cnt[int'(sts_stg)*CNW +: CNW];
    assign qual = sti_transfer & (|sel) & ((evt_in & sel) == sel);
    // Widened compares: occ+1 and dcnt+1 never wrap, and cnt of 0 or 1 meets on the first hit.
    assign met     = ({1'b0, occ} + 1'b1) >= {1'b0, cnt};
    assign last    = cfg_lst[sts_stg] | (sts_stg == SW'(NST-1));
    assign dly_hit = ({1'b0, dcnt} + 1'b1) >= {1'b0, cfg_dly};

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    logic [CNW-1:0] tcnt;

    assign tmo_fire = (state == ARMED) && sti_transfer && !qual && (sts_stg != '0) &&
                      (cfg_tmo != '0) && (({1'b0, tcnt} + 1'b1) >= {1'b0, cfg_tmo});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (ctl_abort || ctl_arm || state != ARMED || sts_stg == '0)
            tcnt <= '0;
        else if (sti_transfer) begin
            if (qual || tmo_fire)
                tcnt <= '0;
            else if (tcnt != '1)
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sts_stg <= '0;
            occ     <= '0;
            dcnt    <= '0;
            sts_arm <= 1'b0;
            sts_trg <= 1'b0;
            sts_dne <= 1'b0;
        end else begin
            sts_trg <= 1'b0;
            if (ctl_abort) begin
                state   <= IDLE;
                sts_stg <= '0;
                occ     <= '0;
                dcnt    <= '0;
                sts_arm <= 1'b0;
                sts_dne <= 1'b0;
            end else if (ctl_arm) begin
                // The sample in the arm cycle is deliberately not evaluated.
                state   <= ARMED;
                sts_stg <= '0;
                occ     <= '0;
                dcnt    <= '0;
                sts_arm <= 1'b1;
                sts_dne <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (qual) begin
                            if (!met)
                                occ <= occ + 1'b1;
                            else if (!last) begin
                                sts_stg <= sts_stg + 1'b1;
                                occ     <= '0;
                            end else if (cfg_dly == '0) begin
                                state   <= DONE;
                                sts_trg <= 1'b1;
                                sts_arm <= 1'b0;
                                sts_dne <= 1'b1;
                            end else begin
                                state <= DELAY;
                                dcnt  <= '0;
                            end
                        end else if (tmo_fire) begin
                            sts_stg <= '0;
                            occ     <= '0;
                        end
                    end
                    DELAY: begin
                        if (sti_transfer) begin
                            if (dly_hit) begin
                                state   <= DONE;
                                sts_trg <= 1'b1;
                                sts_arm <= 1'b0;
                                sts_dne <= 1'b1;
                            end else if (dcnt != '1)
                                dcnt <= dcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios plus randomized traffic
// against a behavioural model built from hit counts and remaining-delay countdowns.
`timescale 1ns/1ps
module tb_trigger_sequencer;
    localparam int NEV = 4;
    localparam int NST = 4;
    localparam int CNW = 16;
    localparam int SW  = $clog2(NST);

    logic               clk = 1'b0;
    logic               rst;
    logic               ctl_arm, ctl_abort, sti_transfer;
    logic [NEV-1:0]     evt_in;
    logic [NST*NEV-1:0] cfg_sel;
    logic [NST*CNW-1:0] cfg_cnt;
    logic [NST-1:0]     cfg_lst;
    logic [CNW-1:0]     cfg_dly;
    logic [CNW-1:0]     cfg_tmo;
    logic               sts_arm, sts_trg, sts_dne;
    logic [SW-1:0]      sts_stg;

    logic [NEV-1:0] sel_a [NST];
    logic [CNW-1:0] cnt_a [NST];

    int errors = 0;
    int checks = 0;

    for (genvar s = 0; s < NST; s++) begin : g_cfg
        assign cfg_sel[s*NEV +: NEV] = sel_a[s];
        assign cfg_cnt[s*CNW +: CNW] = cnt_a[s];
    end

    always #5 clk = ~clk;

    trigger_sequencer #(.NEV(NEV), .NST(NST), .CNW(CNW)) dut (
        .clk(clk), .rst(rst), .ctl_arm(ctl_arm), .ctl_abort(ctl_abort),
        .cfg_sel(cfg_sel), .cfg_cnt(cfg_cnt), .cfg_lst(cfg_lst), .cfg_dly(cfg_dly),
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
        .cfg_tmo(cfg_tmo),
`endif
        .sti_transfer(sti_transfer), .evt_in(evt_in),
        .sts_arm(sts_arm), .sts_stg(sts_stg), .sts_trg(sts_trg), .sts_dne(sts_dne)
    );

    // Reference model: a running sequence, hits in current stage, remaining delay transfers.
    bit m_busy, m_dly, m_done, m_trg;
    int m_stage, m_hits, m_left, m_miss;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_dly = 0; m_done = 0; m_trg = 0;
        m_stage = 0; m_hits = 0; m_left = 0; m_miss = 0;
    endtask

    task automatic model_step(input bit a, input bit ab, input bit x, input logic [NEV-1:0] e);
        logic [NEV-1:0] s;
        bit q;
        int need;
        m_trg = 0;
        if (ab) model_reset();
        else if (a) begin
            model_reset();
            m_busy = 1;
        end else if (m_busy && !m_dly) begin
            s = sel_a[m_stage];
            q = x && (s != 0) && ((e & s) == s);
            need = (cnt_a[m_stage] == 0) ? 1 : int'(cnt_a[m_stage]);
            if (q) begin
                m_miss = 0;
                if (m_hits + 1 >= need) begin
                    if (cfg_lst[m_stage] || m_stage == NST-1) begin
                        if (cfg_dly == 0) begin
                            m_trg = 1; m_busy = 0; m_done = 1;
                        end else begin
                            m_dly = 1; m_left = int'(cfg_dly);
                        end
                    end else begin
                        m_stage++; m_hits = 0;
                    end
                end else m_hits++;
            end
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
            else if (x && m_stage > 0) begin
                m_miss++;
                if (cfg_tmo != 0 && m_miss >= int'(cfg_tmo)) begin
                    m_stage = 0; m_hits = 0; m_miss = 0;
                end
            end
`endif
        end else if (m_busy && m_dly && x) begin
            m_left--;
            if (m_left == 0) begin
                m_trg = 1; m_busy = 0; m_dly = 0; m_done = 1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".arm"}, int'(sts_arm), int'(m_busy));
        chk({tag, ".stg"}, int'(sts_stg), m_stage);
        chk({tag, ".trg"}, int'(sts_trg), int'(m_trg));
        chk({tag, ".dne"}, int'(sts_dne), int'(m_done));
    endtask

    task automatic step(input string tag, input bit a, input bit ab, input bit x, input logic [NEV-1:0] e);
        @(negedge clk);
        ctl_arm = a; ctl_abort = ab; sti_transfer = x; evt_in = e;
        model_step(a, ab, x, e);
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < NST; s++) begin
            sel_a[s] = '0; cnt_a[s] = '0;
        end
        cfg_lst = '0; cfg_dly = '0; cfg_tmo = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ctl_arm = 0; ctl_abort = 0; sti_transfer = 0; evt_in = '0;
        clear_cfg();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Single stage, three hits, no delay
        sel_a[0] = 4'b0001; cnt_a[0] = 3; cfg_lst = 4'b0001;
        step("t1.arm", 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step("t1.hit", 0, 0, 1, 4'b0001);
        chk("t1.trg_pulse", int'(sts_trg), 1);
        step("t1.after", 0, 0, 1, 4'b0001);
        chk("t1.trg_gone", int'(sts_trg), 0);
        chk("t1.dne_hold", int'(sts_dne), 1);

        // Two stages, AND of selected events
        clear_cfg();
        sel_a[0] = 4'b0011; cnt_a[0] = 1; sel_a[1] = 4'b0100; cnt_a[1] = 2; cfg_lst = 4'b0010;
        step("t2.arm", 1, 0, 0, '0);
        step("t2.miss", 0, 0, 1, 4'b0001);
        step("t2.adv", 0, 0, 1, 4'b0011);
        chk("t2.stg1", int'(sts_stg), 1);
        step("t2.h1", 0, 0, 1, 4'b0100);
        step("t2.h2", 0, 0, 1, 4'b0100);
        chk("t2.trg", int'(sts_trg), 1);

        // Delay of 5 transfers with idle gaps
        clear_cfg();
        sel_a[0] = 4'b1000; cnt_a[0] = 1; cfg_lst = 4'b0001; cfg_dly = 5;
        step("t3.arm", 1, 0, 0, '0);
        step("t3.hit", 0, 0, 1, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            step("t3.idle", 0, 0, 0, 4'b1000);
            step("t3.xfer", 0, 0, 1, 4'b0000);
        end
        chk("t3.trg", int'(sts_trg), 1);

        // Arm+abort together in stage 2, then arm mid-delay
        clear_cfg();
        for (int s = 0; s < NST; s++) begin sel_a[s] = 4'b0001; cnt_a[s] = 1; end
        cfg_dly = 3;
        step("t4.arm", 1, 0, 0, '0);
        step("t4.a1", 0, 0, 1, 4'b0001);
        step("t4.a2", 0, 0, 1, 4'b0001);
        chk("t4.stg2", int'(sts_stg), 2);
        step("t4.both", 1, 1, 1, 4'b0001);
        chk("t4.idle_arm", int'(sts_arm), 0);
        chk("t4.idle_stg", int'(sts_stg), 0);
        step("t4.arm2", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step("t4.walk", 0, 0, 1, 4'b0001);
        step("t4.d1", 0, 0, 1, 4'b0000);
        step("t4.rearm", 1, 0, 1, 4'b0000);
        chk("t4.restart_stg", int'(sts_stg), 0);
        step("t4.quiet", 0, 0, 1, 4'b0000);
        chk("t4.no_trg", int'(sts_trg), 0);

        // Async reset mid-delay
        for (int i = 0; i < 4; i++) step("t5.walk", 0, 0, 1, 4'b0001);
        @(negedge clk);
        sti_transfer = 0; evt_in = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs("t5.async");
        @(negedge clk);
        rst = 1'b0;
        step("t5.arm", 1, 0, 0, '0);
        chk("t5.armed", int'(sts_arm), 1);

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
        clear_cfg();
        sel_a[0] = 4'b0001; cnt_a[0] = 1; sel_a[1] = 4'b0010; cnt_a[1] = 1; cfg_lst = 4'b0010; cfg_tmo = 4;
        step("t6.arm", 1, 0, 0, '0);
        step("t6.adv", 0, 0, 1, 4'b0001);
        for (int i = 0; i < 4; i++) step("t6.miss", 0, 0, 1, 4'b0000);
        chk("t6.tmo_stg", int'(sts_stg), 0);
`endif

        // Randomized traffic; configuration only changes in arm cycles
        for (int n = 0; n < 4000; n++) begin
            int r;
            bit a, ab, x;
            logic [NEV-1:0] e;
            r  = $urandom_range(0, 99);
            a  = (r < 2) || (!m_busy && r < 20);
            ab = (r >= 98) || (r == 50);
            if (r == 50) a = 1;
            if (a) begin
                for (int s = 0; s < NST; s++) begin
                    sel_a[s] = 4'($urandom_range(0, 15));
                    cnt_a[s] = 16'($urandom_range(0, 3));
                end
                cfg_lst = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                cfg_dly = 16'($urandom_range(0, 4));
                cfg_tmo = 16'($urandom_range(0, 5));
            end
            x = ($urandom_range(0, 3) != 0);
            e = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) e = e | sel_a[m_stage];
            step("rnd", a, ab, x, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
